// File: rtl/mul_share_pkg.sv
// Shared types and widths for the multiplier-sharing arbiter.
// Operand, product and tag widths, pipeline depth, op/result bundles.
package mul_share_pkg;

    localparam int A_W        = 24;
    localparam int B_W        = 16;
    localparam int P_W        = 40;
    localparam int PIPE_DEPTH = 3;
    localparam int TAG_MAX_W  = 3;

    typedef logic [TAG_MAX_W-1:0] tag_t;

    typedef struct packed {
        logic signed [A_W-1:0] a;
        logic signed [B_W-1:0] b;
        tag_t                  tag;
    } op_t;

    typedef struct packed {
        logic signed [P_W-1:0] p;
        tag_t                  tag;
    } res_t;

endpackage

// File: rtl/mul_share_arbiter_if.sv
// Requester/result bundle of the shared multiplier.
// master: requesters (valid, a, b, res_ready); slave: the arbiter.
interface mul_share_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import mul_share_pkg::*;

    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*A_W-1:0] req_a;
    logic [NUM_REQ*B_W-1:0] req_b;
    logic [NUM_REQ-1:0]     res_valid;
    logic [NUM_REQ-1:0]     res_ready;
    logic signed [P_W-1:0]  res_p;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_p
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_p
    );

endinterface

// File: rtl/mul_share_rr_pick.sv
// Combinational round-robin picker: first set req at or after rr_ptr+1.
// Ports: req, rr_ptr in; one-hot grant, encoded idx, any out.
module mul_share_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [TAG_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [TAG_W-1:0]   idx,
    output logic               any
);

    always_comb begin
        int               c;
        logic [TAG_W-1:0] ci;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        c     = 0;
        ci    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            c  = (int'(rr_ptr) + k) % NUM_REQ;
            ci = TAG_W'(c);
            if (!any && req[ci]) begin
                any       = 1'b1;
                grant[ci] = 1'b1;
                idx       = ci;
            end
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// One pipelined signed 24x16 multiplier shared round-robin by NUM_REQ
// requesters; tagged results return to their owner, any result stall
// freezes the whole pipe via ce.
// Ports: ap_clk, ap_rst_n (async, low), bus (slave modport),
// stat_done_cnt (retire count when MUL_SHARE_STATS_EN is defined, else 0).
module mul_share_arbiter
    import mul_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = $clog2(NUM_REQ)
) (
    input  logic                ap_clk,
    input  logic                ap_rst_n,
    mul_share_arbiter_if.slave  bus,
    output logic [31:0]         stat_done_cnt
);

    logic [NUM_REQ-1:0]    grant;
    logic [TAG_W-1:0]      pick_idx;
    logic [TAG_W-1:0]      rr_ptr;
    logic [TAG_W-1:0]      head_idx;
    logic                  any;
    logic                  ce;

    logic signed [A_W-1:0] a_arr [NUM_REQ];
    logic signed [B_W-1:0] b_arr [NUM_REQ];

    // vld[0]=issue, vld[1]=operand reg, vld[2]=product reg
    logic [PIPE_DEPTH-1:0] vld;
    op_t                   iss;
    tag_t                  tag1;
    logic signed [A_W-1:0] mul_a;
    logic signed [B_W-1:0] mul_b;
    res_t                  s2;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign a_arr[i] = bus.req_a[i*A_W +: A_W];
        assign b_arr[i] = bus.req_b[i*B_W +: B_W];
        assign bus.res_valid[i] = vld[PIPE_DEPTH-1]
                                & (s2.tag == tag_t'(i));
    end

    mul_share_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .TAG_W   (TAG_W)
    ) u_pick (
        .req    (bus.req_valid),
        .rr_ptr (rr_ptr),
        .grant  (grant),
        .idx    (pick_idx),
        .any    (any)
    );

    // Only the addressed requester's res_ready can stall the pipe.
    assign head_idx      = TAG_W'(s2.tag);
    assign ce            = ~(vld[PIPE_DEPTH-1] & ~bus.res_ready[head_idx]);
    assign bus.req_ready = grant & {NUM_REQ{ce}};
    assign bus.res_p     = s2.p;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            vld    <= '0;
            rr_ptr <= TAG_W'(NUM_REQ - 1);
        end else if (ce) begin
            vld <= {vld[PIPE_DEPTH-2:0], any};
            if (any) rr_ptr <= pick_idx;
        end
    end

    // Datapath and tags carry no reset; the vld bits qualify them.
    always_ff @(posedge ap_clk) begin
        if (ce) begin
            if (any) begin
                iss.a   <= a_arr[pick_idx];
                iss.b   <= b_arr[pick_idx];
                iss.tag <= tag_t'(pick_idx);
            end
            mul_a <= iss.a;
            mul_b <= iss.b;
            tag1  <= iss.tag;
            s2.p  <= $signed({{(P_W-A_W){mul_a[A_W-1]}}, mul_a})
                   * $signed({{(P_W-B_W){mul_b[B_W-1]}}, mul_b});
            s2.tag <= tag1;
        end
    end

`ifdef MUL_SHARE_STATS_EN
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)
            stat_done_cnt <= '0;
        else if (vld[PIPE_DEPTH-1] & ce)
            stat_done_cnt <= stat_done_cnt + 32'd1;
    end
`else
    assign stat_done_cnt = '0;
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Randomized self-checking bench for mul_share_arbiter.
// Reference model: queue of in-flight ops aged by non-stalled cycles.
module tb_mul_share_arbiter;
    import mul_share_pkg::*;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] stat;

    always #5 clk = ~clk;

    mul_share_arbiter_if #(.NUM_REQ(N)) bus();

    mul_share_arbiter #(.NUM_REQ(N)) dut (
        .ap_clk        (clk),
        .ap_rst_n      (rst_n),
        .bus           (bus),
        .stat_done_cnt (stat)
    );

    typedef struct {
        int                    tag;
        logic signed [P_W-1:0] p;
        int                    age;
    } ent_t;

    ent_t                  q[$];
    logic signed [P_W-1:0] got_p[$];
    logic [N-1:0]          pend;
    logic signed [A_W-1:0] pa [N];
    logic signed [B_W-1:0] pb [N];
    logic [N-1:0]          last_rdy_out;
    int rr, n_chk, n_fail, retired, accepted;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int exp_stat();
`ifdef MUL_SHARE_STATS_EN
        return retired;
`else
        return 0;
`endif
    endfunction

    task automatic load(input int i, input logic signed [A_W-1:0] a,
                        input logic signed [B_W-1:0] b);
        pend[i] = 1'b1;
        pa[i]   = a;
        pb[i]   = b;
    endtask

    function automatic logic [N-1:0] rand_rdy();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = ($urandom_range(3) != 0);
        return r;
    endfunction

    // One clock: drive at negedge, check just after, advance model.
    task automatic step(input logic [N-1:0] rdy, input int prob);
        int           g, c;
        bit           hv, ce;
        logic [N-1:0] erv, err;
        ent_t         e;
        @(negedge clk);
        for (int i = 0; i < N; i++)
            if (!pend[i] && $urandom_range(99) < prob)
                load(i, A_W'($urandom), B_W'($urandom));
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]          = pend[i];
            bus.req_a[i*A_W +: A_W]   = pend[i] ? pa[i] : A_W'($urandom);
            bus.req_b[i*B_W +: B_W]   = pend[i] ? pb[i] : B_W'($urandom);
        end
        bus.res_ready = rdy;
        #1;
        hv  = (q.size() > 0) && (q[0].age == PIPE_DEPTH);
        erv = '0;
        ce  = 1'b1;
        if (hv) begin
            erv = N'(1) << q[0].tag;
            if (!rdy[q[0].tag]) ce = 1'b0;
        end
        g = -1;
        if (ce)
            for (int k = 1; k <= N; k++) begin
                c = (rr + k) % N;
                if (g < 0 && pend[c]) g = c;
            end
        err = (g >= 0) ? (N'(1) << g) : '0;
        check("res_valid", bus.res_valid, erv);
        check("req_ready", bus.req_ready, err);
        last_rdy_out = bus.req_ready;
        if (hv) check("res_p", bus.res_p, q[0].p);
        if (ce) begin
            if (hv) begin
                got_p.push_back(bus.res_p);
                void'(q.pop_front());
                retired++;
            end
            foreach (q[j]) q[j].age++;
            if (g >= 0) begin
                e.tag = g;
                e.p   = pa[g] * pb[g];
                e.age = 1;
                q.push_back(e);
                pend[g] = 1'b0;
                rr = g;
                accepted++;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid = '0;
        #1;
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_stat", stat, 0);
        q.delete();
        pend = '0;
        rr = N - 1;
        retired = 0;
        accepted = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int           stall;
        logic [N-1:0] rdy;
        n_chk = 0;
        n_fail = 0;
        pend = '0;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.res_ready = '1;
        do_reset();

        got_p.delete();
        load(1, -24'sd3, 16'sd7);
        repeat (6) step('1, 0);
        check("single_n", got_p.size(), 1);
        if (got_p.size() == 1) check("single_p", got_p[0], -40'sd21);

        got_p.delete();
        load(0, 24'h800000, 16'h8000);
        load(3, 24'h7FFFFF, 16'h8000);
        repeat (8) step('1, 0);
        check("ext_n", got_p.size(), 2);
        if (got_p.size() == 2) begin
            check("ext_pos_max", got_p[1], 40'sh40_0000_0000);
            check("ext_neg", got_p[0], -40'sd274877874176);
        end

        repeat (40) step('1, 100);

        stall = 0;
        for (int k = 0; k < 40; k++) begin
            rdy = '1;
            if (q.size() > 0 && q[0].age == PIPE_DEPTH &&
                q[0].tag == 2 && stall < 5) begin
                rdy = 4'b1011;
                stall++;
            end
            step(rdy, 100);
        end
        repeat (8) step('1, 0);
        check("stat_stall", stat, exp_stat());

        repeat (1500) step(rand_rdy(), 40);
        repeat (8) step('1, 0);
        check("stat_rand", stat, exp_stat());

        repeat (3) step('1, 100);
        do_reset();
        load(0, A_W'($urandom), B_W'($urandom));
        load(1, A_W'($urandom), B_W'($urandom));
        step('1, 0);
        check("rst_grant", last_rdy_out, 4'b0001);
        for (int k = 0; k < 40; k++) begin
            if (!pend[0] &&
                accepted + int'(pend[0]) + int'(pend[1]) < 10)
                load(0, A_W'($urandom), B_W'($urandom));
            step('1, 0);
        end
        repeat (8) step('1, 0);
`ifdef MUL_SHARE_STATS_EN
        check("stat_ten", stat, 10);
`else
        check("stat_ten", stat, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
